boot_loader: RTL
================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL: i_clk, input, 1, sole clock, rising-edge.
REQ-002 SHALL: i_rstn, input, 1, asynchronous active-low reset.
REQ-003 SHALL: i_bootStart, input, 1, one-cycle start request from the uP state machine.
REQ-004 SHALL: o_bootMemAddr, output, 16, memory write address to the memory controller.
REQ-005 SHALL: o_bootDataOut, output, 16, memory write data to the memory controller.
REQ-006 SHALL: o_bootMemEn, output, 1, one-cycle write strobe; the controller treats boot accesses as writes.
REQ-007 SHALL: o_bootDone, output, 1, sticky flag meaning the image load has finished.
REQ-008 SHALL: o_bootErr, output, 1, sticky flag meaning the image was rejected.
REQ-009 SHALL: o_spiCsN, output, 1, EEPROM chip select, active-low.
REQ-010 SHALL: o_spiSclk, output, 1, SPI clock.
REQ-011 SHALL: o_spiMosi, output, 1, SPI data out.
REQ-012 SHALL: i_spiMiso, input, 1, SPI data in.

Function
REQ-013 SHALL: use SPI mode 0 with SCLK = i_clk/2, so one bit takes 2 cycles; MOSI changes while SCLK is low and MISO is sampled on the cycle SCLK rises; all bits are MSB first.
REQ-014 SHALL: step through the states IDLE -> CMD -> LEN -> DATA -> (CSUM) -> DONE.
REQ-015 SHALL: in IDLE, hold CsN=1, SCLK=0 and MOSI=0, and go to CMD on i_bootStart=1.
REQ-016 SHALL: in CMD, drive CsN=0 and shift out 24 bits: 0x03 followed by address 0x0000.
REQ-017 SHALL: in LEN, shift in 16 bits as the word count N.
REQ-018 SHALL: clamp N to 0xC000 (`BOOT_MAX_WORDS`) so the mapped-register space is never targeted.
REQ-019 SHALL: in LEN, go to DONE (or CSUM when the macro is set) when N=0.
REQ-020 SHALL: in DATA, shift in 16-bit words; for word k (k = 0..N-1), pulse o_bootMemEn for exactly 1 cycle, on the cycle after its 16th bit is sampled.
REQ-021 SHALL: hold o_bootMemAddr=k and o_bootDataOut=word during that strobe cycle.
REQ-022 SHALL: keep SCLK running through the strobe, so words are back-to-back with no extra gap; the strobe period is 32 cycles.
REQ-023 SHALL: leave DATA after word N-1 is strobed; the 16-bit word counter never wraps because N ≤ 0xC000.
REQ-024 SHALL: in DONE, drive CsN=1 and SCLK=0 and hold o_bootDone=1 until reset; i_bootStart is then ignored.
REQ-025 SHALL: ignore i_bootStart in every state other than IDLE.
REQ-026 SHALL: hold o_bootMemEn=0 in every state except the strobe cycle.

Reset
REQ-027 SHALL: on i_rstn=0, at any time including mid-word or mid-command, immediately go to IDLE.
REQ-028 SHALL: on reset, set o_bootMemAddr=0, o_bootDataOut=0, o_bootMemEn=0, o_bootDone=0, o_bootErr=0, o_spiCsN=1, o_spiSclk=0, o_spiMosi=0, and clear all counters and shift registers.
REQ-029 SHALL: discard any partially received word on reset; nothing is written.

Configuration
REQ-030 SHALL: with `BOOT_CHECKSUM_EN` defined, keep a running 16-bit sum (mod 2^16) of data words, then in CSUM read one further 16-bit word.
REQ-031 SHALL: on a mismatch in CSUM, set o_bootErr=1; in either case, then go to DONE.
REQ-032 SHALL: without `BOOT_CHECKSUM_EN`, omit CSUM and the accumulator, and tie o_bootErr to 0.

Structure
REQ-033 SHALL: place in package boot_pkg: the state enum, `BOOT_READ_CMD`=8'h03, `BOOT_MAX_WORDS`=16'hC000, and `BOOT_CMD_BITS`=24.
REQ-034 SHALL: implement SCLK generation, the MOSI shift-out and the MISO 16-bit shift-in in one sub-module, boot_spi_shifter, which signals "bit-count reached"; the FSM, counters and bus outputs stay in boot_loader.

Verification
REQ-035 SHALL: cover basic load: image N=3, words 0x1111/0x2222/0x3333 -> exactly 3 strobes, addr 0,1,2 carrying those data, strobes 32 cycles apart, done=1 afterwards.
REQ-036 SHALL: cover empty image: N=0 -> no strobe, done=1, CsN returns to 1.
REQ-037 SHALL: cover clamp: N=0xFFFF -> last strobe at addr 0xBFFF, no address ≥0xC000 ever driven.
REQ-038 SHALL: cover mid-word reset: rstn=0 at bit 7 of word 2 -> outputs at reset values within the same cycle, no strobe, and a restart after a new i_bootStart reloads the image from addr 0.
REQ-039 SHALL: cover checksum (macro set): words 0x0001/0xFFFF with checksum 0x0000 -> err=0; with checksum 0x1234 -> err=1; done=1 in both cases.
REQ-040 SHALL: cover command framing: a monitor samples 0x03,0x00,0x00 on MOSI during the first 48 cycles after start, with CsN low throughout.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and constants for the SPI EEPROM boot loader.
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE
    } boot_state_e;

    localparam logic [7:0]  BOOT_READ_CMD  = 8'h03;
    localparam logic [15:0] BOOT_MAX_WORDS = 16'hC000;
    localparam int unsigned BOOT_CMD_BITS  = 24;
    localparam int unsigned BOOT_WORD_BITS = 16;

    // Keeps the image out of the mapped-register space above BOOT_MAX_WORDS.
    function automatic logic [15:0] clamp_len(input logic [15:0] n);
        return (n > BOOT_MAX_WORDS) ? BOOT_MAX_WORDS : n;
    endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Boot write port towards the memory controller (every access is a write).
interface boot_loader_if;

    logic [15:0] o_bootMemAddr;
    logic [15:0] o_bootDataOut;
    logic        o_bootMemEn;

    modport master (output o_bootMemAddr, output o_bootDataOut, output o_bootMemEn);
    modport slave  (input  o_bootMemAddr, input  o_bootDataOut, input  o_bootMemEn);

endinterface

// File: rtl/boot_spi_shifter.sv
// SPI mode-0 master datapath: SCLK = clk/2, MSB-first shift-out and 16-bit shift-in.
module boot_spi_shifter
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        load,
    input  logic [4:0]  n_bits,
    input  logic [23:0] load_data,
    input  logic        miso,
    output logic        sclk,
    output logic        mosi,
    output logic        hit,
    output logic [15:0] rx_word
);

    logic        sclk_q, sclk_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [23:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;

    // hit marks the edge that samples the last bit of the current field;
    // rx_word already includes that bit so the caller can use it on the same edge.
    assign hit     = !sclk_q && (cnt_q == n_bits - 5'd1);
    assign rx_word = {rx_q[BOOT_WORD_BITS-2:0], miso};
    assign sclk    = sclk_q;
    assign mosi    = tx_q[23];

    always_comb begin
        sclk_d = sclk_q;
        cnt_d  = cnt_q;
        tx_d   = tx_q;
        rx_d   = rx_q;
        if (load) begin
            sclk_d = 1'b0;
            cnt_d  = '0;
            tx_d   = load_data;
            rx_d   = '0;
        end else if (!run) begin
            sclk_d = 1'b0;
            cnt_d  = '0;
            tx_d   = '0;
            rx_d   = '0;
        end else if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = rx_word;
            cnt_d  = hit ? '0 : cnt_q + 5'd1;
        end else begin
            sclk_d = 1'b0;
            tx_d   = {tx_q[22:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= 1'b0;
            cnt_q  <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
        end else begin
            sclk_q <= sclk_d;
            cnt_q  <= cnt_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Boot loader: reads a length-prefixed image from SPI EEPROM and writes it to memory.
// Optional trailing checksum verification is enabled by defining BOOT_CHECKSUM_EN.
module boot_loader
    import boot_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_bootStart,
    output logic          o_bootDone,
    output logic          o_bootErr,
    output logic          o_spiCsN,
    output logic          o_spiSclk,
    output logic          o_spiMosi,
    input  logic          i_spiMiso,
    boot_loader_if.master mem
);

`ifdef BOOT_CHECKSUM_EN
    localparam boot_state_e POST_DATA = ST_CSUM;
`else
    localparam boot_state_e POST_DATA = ST_DONE;
`endif

    boot_state_e state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [15:0] k_q, k_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        mem_en_q, mem_en_d;
    logic        done_q, done_d;
    logic        csn_q, csn_d;

    logic        spi_run;
    logic        spi_load;
    logic        spi_hit;
    logic [4:0]  spi_bits;
    logic [15:0] rx_word;

`ifdef BOOT_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;
    logic        err_q, err_d;
`endif

    assign spi_bits = (state_q == ST_CMD) ? 5'(BOOT_CMD_BITS) : 5'(BOOT_WORD_BITS);
    // Driven from the next state so SCLK is already low on the first DONE cycle.
    assign spi_run  = (state_d != ST_IDLE) && (state_d != ST_DONE);

    boot_spi_shifter u_shifter (
        .clk       (i_clk),
        .rst_n     (i_rstn),
        .run       (spi_run),
        .load      (spi_load),
        .n_bits    (spi_bits),
        .load_data ({BOOT_READ_CMD, 16'h0000}),
        .miso      (i_spiMiso),
        .sclk      (o_spiSclk),
        .mosi      (o_spiMosi),
        .hit       (spi_hit),
        .rx_word   (rx_word)
    );

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        k_d      = k_q;
        addr_d   = addr_q;
        data_d   = data_q;
        mem_en_d = 1'b0;
        done_d   = done_q;
        spi_load = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        sum_d    = sum_q;
        err_d    = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_bootStart) begin
                    state_d  = ST_CMD;
                    spi_load = 1'b1;
                    k_d      = '0;
`ifdef BOOT_CHECKSUM_EN
                    sum_d    = '0;
`endif
                end
            end
            ST_CMD: begin
                if (spi_hit) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (spi_hit) begin
                    n_d     = clamp_len(rx_word);
                    state_d = (rx_word == '0) ? POST_DATA : ST_DATA;
                end
            end
            ST_DATA: begin
                if (spi_hit) begin
                    mem_en_d = 1'b1;
                    addr_d   = k_q;
                    data_d   = rx_word;
                    k_d      = k_q + 16'd1;
`ifdef BOOT_CHECKSUM_EN
                    sum_d    = sum_q + rx_word;
`endif
                    if (k_q + 16'd1 == n_q) state_d = POST_DATA;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CSUM: begin
                if (spi_hit) begin
                    err_d   = (rx_word != sum_q);
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: ;
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_DONE) done_d = 1'b1;
        csn_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= ST_IDLE;
            n_q      <= '0;
            k_q      <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            mem_en_q <= 1'b0;
            done_q   <= 1'b0;
            csn_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            k_q      <= k_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            mem_en_q <= mem_en_d;
            done_q   <= done_d;
            csn_q    <= csn_d;
        end
    end

`ifdef BOOT_CHECKSUM_EN
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end
    assign o_bootErr = err_q;
`else
    assign o_bootErr = 1'b0;
`endif

    assign mem.o_bootMemAddr = addr_q;
    assign mem.o_bootDataOut = data_q;
    assign mem.o_bootMemEn   = mem_en_q;
    assign o_bootDone        = done_q;
    assign o_spiCsN          = csn_q;

endmodule
